// File: rtl/idc_pkg.sv
// Shared definitions for the image display controller output stage:
// frame geometry, pixel widths and the write/read FSM state encodings.
package idc_pkg;

   localparam int FRAME_PIX = 16;
   localparam int IDX_W     = 4;
   localparam int ROW_W     = 2;
   localparam int COL_W     = 2;
   localparam int IN_W      = 7;
   localparam int PIX_W     = 8;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_DROP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_SEND = 1'b1
   } rd_state_e;

endpackage

// File: rtl/idc_display_out_if.sv
// Bus bundle between the controller, the display stage and the panel.
// The cksum signal exists only when IDC_DISP_CKSUM_EN is defined.
interface idc_display_out_if;
   import idc_pkg::*;

   logic                    in_valid;
   logic signed [IN_W-1:0]  in_data;
   logic                    pix_ready;
   logic                    pix_valid;
   logic [PIX_W-1:0]        pix_data;
   logic [ROW_W-1:0]        pix_row;
   logic [COL_W-1:0]        pix_col;
   logic                    frame_done;
   logic [PIX_W-1:0]        drop_cnt;
   logic                    busy;
`ifdef IDC_DISP_CKSUM_EN
   logic [PIX_W-1:0]        cksum;
`endif

   // display stage side
   modport slave (
      input  in_valid, in_data, pix_ready,
      output pix_valid, pix_data, pix_row, pix_col, frame_done, drop_cnt, busy
`ifdef IDC_DISP_CKSUM_EN
      , output cksum
`endif
   );

   // controller/panel side
   modport master (
      output in_valid, in_data, pix_ready,
      input  pix_valid, pix_data, pix_row, pix_col, frame_done, drop_cnt, busy
`ifdef IDC_DISP_CKSUM_EN
      , input cksum
`endif
   );

endinterface

// File: rtl/idc_frame_bank.sv
// One 16 x 8 frame bank: single write port, combinational read port.
// Contents are data only and are never reset.
module idc_frame_bank
   import idc_pkg::*;
(
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_addr,
   input  logic [PIX_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0] i_rd_addr,
   output logic [PIX_W-1:0] o_rd_data
);

   logic [PIX_W-1:0] r_mem [FRAME_PIX];

   // capture one pixel per write strobe
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/idc_display_out.sv
// Display output stage: captures 4x4 signed frames into a ping-pong buffer
// and replays them to the panel under valid/ready. Frames arriving while
// both banks are held are dropped and counted.
// Optional feature: IDC_DISP_CKSUM_EN adds a per-frame mod-256 checksum.
module idc_display_out
   import idc_pkg::*;
#(
   parameter int OFFSET = 64
) (
   input logic             clk,
   input logic             rst,
   idc_display_out_if.slave disp
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIX - 1);
   localparam logic [PIX_W-1:0] OFF8     = PIX_W'(OFFSET);

   // Sign-extend and shift into the unsigned brightness range, wrapping mod 256.
   function automatic logic [PIX_W-1:0] to_bright(input logic signed [IN_W-1:0] d);
      logic signed [PIX_W-1:0] ext;
      ext = {d[IN_W-1], d};
      return $unsigned(ext) + OFF8;
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
      return (v == {PIX_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   wr_state_e        r_wstate, w_wstate_nxt;
   rd_state_e        r_rstate, w_rstate_nxt;
   logic [IDX_W-1:0] r_wr_idx, r_rd_idx;
   logic             r_wr_sel, r_rd_sel;
   logic [1:0]       r_full;
   logic [PIX_W-1:0] r_drop_cnt;
   logic             r_busy;
   logic             r_pix_valid;
   logic [PIX_W-1:0] r_pix_data;

   logic             w_hs, w_last_hs, w_tgt_free;
   logic             w_wr_en, w_fill_done, w_drop_evt;
   logic [IDX_W-1:0] w_wr_addr;
   logic [PIX_W-1:0] w_wr_data;
   logic             w_load, w_unload, w_rd_bank;
   logic [IDX_W-1:0] w_rd_addr;
   logic [PIX_W-1:0] w_bank_q [2];

   assign w_hs       = r_pix_valid & disp.pix_ready;
   assign w_last_hs  = w_hs & (r_rstate == R_SEND) & (r_rd_idx == LAST_IDX);
   // a bank being released by the reader this cycle is already free for the writer
   assign w_tgt_free = ~r_full[r_wr_sel] | (w_last_hs & (r_rd_sel == r_wr_sel));
   assign w_wr_data  = to_bright(disp.in_data);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      idc_frame_bank u_bank (
         .clk       (clk),
         .i_wr_en   (w_wr_en & (r_wr_sel == 1'(b))),
         .i_wr_addr (w_wr_addr),
         .i_wr_data (w_wr_data),
         .i_rd_addr (w_rd_addr),
         .o_rd_data (w_bank_q[b])
      );
   end

   // write FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_nxt;
   end

   // write FSM next state: start, complete, abort or swallow a frame
   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE: if (disp.in_valid) w_wstate_nxt = w_tgt_free ? W_FILL : W_DROP;
         W_FILL: if (!disp.in_valid || (r_wr_idx == LAST_IDX)) w_wstate_nxt = W_IDLE;
         W_DROP: if (!disp.in_valid) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   // write FSM outputs: bank strobe, frame completion and drop events
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_addr   = '0;
      w_fill_done = 1'b0;
      w_drop_evt  = 1'b0;
      case (r_wstate)
         W_IDLE: w_wr_en = disp.in_valid & w_tgt_free;
         W_FILL: begin
            w_wr_en     = disp.in_valid;
            w_wr_addr   = r_wr_idx;
            w_fill_done = disp.in_valid & (r_wr_idx == LAST_IDX);
            w_drop_evt  = ~disp.in_valid;
         end
         W_DROP: w_drop_evt = ~disp.in_valid;
         default: ;
      endcase
   end

   // write pointer, bank select and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_idx   <= '0;
         r_wr_sel   <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_wr_en)     r_wr_idx   <= w_wr_addr + 1'b1;
         if (w_fill_done) r_wr_sel   <= ~r_wr_sel;
         if (w_drop_evt)  r_drop_cnt <= sat_inc(r_drop_cnt);
      end
   end

   // bank occupancy: writer sets on completion, reader clears after pixel 15
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full <= 2'b00;
      end else begin
         if (w_fill_done) r_full[r_wr_sel] <= 1'b1;
         if (w_last_hs)   r_full[r_rd_sel] <= 1'b0;
      end
   end

   // read FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_nxt;
   end

   // read FSM next state: go idle only when no further frame is waiting
   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE: if (r_full[r_rd_sel]) w_rstate_nxt = R_SEND;
         R_SEND: if (w_last_hs && !r_full[~r_rd_sel]) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // read FSM outputs: which bank/pixel to load into the output registers
   always_comb begin
      w_load    = 1'b0;
      w_unload  = 1'b0;
      w_rd_bank = r_rd_sel;
      w_rd_addr = '0;
      case (r_rstate)
         R_IDLE: w_load = r_full[r_rd_sel];
         R_SEND: begin
            if (w_hs) begin
               if (r_rd_idx != LAST_IDX) begin
                  w_load    = 1'b1;
                  w_rd_addr = r_rd_idx + 1'b1;
               end else if (r_full[~r_rd_sel]) begin
                  w_load    = 1'b1;
                  w_rd_bank = ~r_rd_sel;
               end else begin
                  w_unload  = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // output registers hold steady until the panel takes the pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_sel    <= 1'b0;
         r_rd_idx    <= '0;
         r_pix_valid <= 1'b0;
         r_pix_data  <= '0;
      end else begin
         if (w_last_hs) r_rd_sel <= ~r_rd_sel;
         if (w_load) begin
            r_pix_valid <= 1'b1;
            r_pix_data  <= w_bank_q[w_rd_bank];
            r_rd_idx    <= w_rd_addr;
         end else if (w_unload) begin
            r_pix_valid <= 1'b0;
         end
      end
   end

   // busy reflects the previous cycle's occupancy and fill activity
   always_ff @(posedge clk) begin
      if (rst) r_busy <= 1'b0;
      else     r_busy <= (|r_full) | (r_wstate == W_FILL);
   end

`ifdef IDC_DISP_CKSUM_EN
   logic [PIX_W-1:0] r_acc, r_cksum;

   // running sum of handshaken pixels, latched at the end of each frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_cksum <= '0;
      end else if (w_last_hs) begin
         r_acc   <= '0;
         r_cksum <= r_acc + r_pix_data;
      end else if (w_hs) begin
         r_acc   <= r_acc + r_pix_data;
      end
   end

   // the final sum is visible already in the frame_done cycle
   assign disp.cksum = w_last_hs ? (r_acc + r_pix_data) : r_cksum;
`endif

   assign disp.pix_valid  = r_pix_valid;
   assign disp.pix_data   = r_pix_data;
   assign disp.pix_row    = r_rd_idx[IDX_W-1 -: ROW_W];
   assign disp.pix_col    = r_rd_idx[COL_W-1:0];
   assign disp.frame_done = w_last_hs;
   assign disp.drop_cnt   = r_drop_cnt;
   assign disp.busy       = r_busy;

endmodule
